pipeline_hazard_ctrl: RTL and testbench

//  Parametrised pipeline control for the RV32I core; next generation of the fixed 5-stage controller.
//  - Tracks per-stage valid bits and generates per-buffer load enables.
//  - Squashes younger stages on a taken jump/branch resolved in EX.
//  - Inserts a load-use bubble.
//  - Advances the pipeline only after both instruction and data memory have responded. The two

---
 rtl/pipeline_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control for the RV32I core: per-stage valids, buffer load enables, redirect squash,
// load-use bubble and the I/D memory response handshake. Perf counters exist when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int NSTAGE  = 5,
    parameter int EX_STG  = 2,
    parameter int MEM_STG = 3,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_mem_resp,
    output logic              inst_mem_read,
    input  logic              data_rd_req,
    input  logic              data_wr_req,
    input  logic              data_mem_resp,
    output logic              data_mem_read,
    output logic              data_mem_write,
    input  logic              ex_is_jal,
    input  logic              ex_is_jalr,
    input  logic              ex_is_br,
    input  logic              br_en,
    input  logic              load_use,
    output logic              advance,
    output logic [1:0]        pc_mux_sel,
    output logic [NSTAGE-1:0] stage_load,
    output logic [NSTAGE-1:0] stage_valid
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    if (NSTAGE < 4 || NSTAGE > 8 || EX_STG < 1 || MEM_STG <= EX_STG ||
        MEM_STG >= NSTAGE || CNT_W < 1) begin : g_param_check
        $error("pipeline_hazard_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        I_DONE = 2'd1,
        D_DONE = 2'd2
    } mem_state_e;

    mem_state_e        state_q, state_d;
    logic [NSTAGE-1:0] valid_q, valid_d;
    logic              i_done, d_done;
    logic              dreq, ig, dg;
    logic              redir, bubble;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            valid_q <= NSTAGE'(1);
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    // Done flags live in the FSM state: each remembers a response until its partner arrives.
    always_comb begin
        state_d        = state_q;
        i_done         = (state_q == I_DONE);
        d_done         = (state_q == D_DONE);
        dreq           = valid_q[MEM_STG] & (data_rd_req | data_wr_req);
        ig             = i_done | inst_mem_resp;
        dg             = ~dreq | d_done | data_mem_resp;
        advance        = rst & ig & dg;
        inst_mem_read  = rst & ~i_done;
        data_mem_read  = rst & dreq & data_rd_req & ~d_done;
        data_mem_write = rst & dreq & data_wr_req & ~d_done;

        if (advance) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (inst_mem_resp && !dg) begin
                        state_d = I_DONE;
                    end else if (dreq && data_mem_resp && !ig) begin
                        state_d = D_DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        redir      = valid_q[EX_STG] & (ex_is_jal | ex_is_jalr | (ex_is_br & br_en));
        bubble     = load_use & ~redir;
        pc_mux_sel = 2'd0;
        if (rst && valid_q[EX_STG]) begin
            if (ex_is_jalr) begin
                pc_mux_sel = 2'd2;
            end else if (ex_is_jal || (ex_is_br && br_en)) begin
                pc_mux_sel = 2'd1;
            end
        end

        for (int i = 0; i < NSTAGE; i++) begin
            stage_load[i] = advance & ~(bubble & (i < EX_STG));
        end

        // Redirect squashes the two youngest instructions; otherwise load-use freezes the front end.
        valid_d = valid_q;
        if (advance) begin
            valid_d = {valid_q[NSTAGE-2:0], 1'b1};
            if (redir) begin
                valid_d[EX_STG:1] = '0;
            end else if (bubble) begin
                valid_d[EX_STG-1:0] = valid_q[EX_STG-1:0];
                valid_d[EX_STG]     = 1'b0;
            end
        end
    end

    assign stage_valid = valid_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!advance || bubble) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (advance && redir) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a flag/array model of the pipeline rules.
module tb_pipeline_hazard_ctrl;
    localparam int NS  = 5;
    localparam int EX  = 2;
    localparam int MEM = 3;
    localparam int CW  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          inst_mem_resp = 1'b0, data_rd_req = 1'b0, data_wr_req = 1'b0;
    logic          data_mem_resp = 1'b0, ex_is_jal = 1'b0, ex_is_jalr = 1'b0;
    logic          ex_is_br = 1'b0, br_en = 1'b0, load_use = 1'b0;
    logic          inst_mem_read, data_mem_read, data_mem_write, advance;
    logic [1:0]    pc_mux_sel;
    logic [NS-1:0] stage_load, stage_valid;
`ifdef PIPE_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    pipeline_hazard_ctrl #(.NSTAGE(NS), .EX_STG(EX), .MEM_STG(MEM), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .inst_mem_resp(inst_mem_resp), .inst_mem_read(inst_mem_read),
        .data_rd_req(data_rd_req), .data_wr_req(data_wr_req),
        .data_mem_resp(data_mem_resp), .data_mem_read(data_mem_read),
        .data_mem_write(data_mem_write),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_is_br(ex_is_br), .br_en(br_en),
        .load_use(load_use), .advance(advance), .pc_mux_sel(pc_mux_sel),
        .stage_load(stage_load), .stage_valid(stage_valid)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: which stages hold live instructions, and which memory responses are banked.
    bit          m_valid[NS];
    bit          m_igot, m_dgot;
    int unsigned m_stall, m_flush;

    always @(negedge clk) begin
        bit            dreq, iok, dok, adv, redir, hold_front;
        logic [1:0]    epc;
        logic [NS-1:0] eload, evalid;
        bit            nv[NS];

        if (!rst) begin
            for (int i = 0; i < NS; i++) m_valid[i] = (i == 0);
            m_igot  = 0;
            m_dgot  = 0;
            m_stall = 0;
            m_flush = 0;
        end

        dreq  = m_valid[MEM] && (data_rd_req || data_wr_req);
        iok   = m_igot || inst_mem_resp;
        dok   = !dreq || m_dgot || data_mem_resp;
        adv   = rst && iok && dok;
        redir = m_valid[EX] && (ex_is_jal || ex_is_jalr || (ex_is_br && br_en));
        hold_front = load_use && !redir;

        epc = 2'd0;
        if (rst && m_valid[EX]) begin
            if (ex_is_jalr) epc = 2'd2;
            else if (ex_is_jal || (ex_is_br && br_en)) epc = 2'd1;
        end
        for (int i = 0; i < NS; i++) begin
            evalid[i] = m_valid[i];
            eload[i]  = adv && !(hold_front && i < EX);
        end

        chk("stage_valid", stage_valid, evalid);
        chk("inst_mem_read", inst_mem_read, rst && !m_igot);
        chk("data_mem_read", data_mem_read, rst && dreq && data_rd_req && !m_dgot);
        chk("data_mem_write", data_mem_write, rst && dreq && data_wr_req && !m_dgot);
        chk("advance", advance, adv);
        chk("pc_mux_sel", pc_mux_sel, epc);
        chk("stage_load", stage_load, eload);
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
`endif

        if (rst) begin
            if (!adv || hold_front) m_stall++;
            if (adv && redir) m_flush++;
            for (int i = 0; i < NS; i++) nv[i] = m_valid[i];
            if (adv) begin
                for (int i = NS - 1; i > EX; i--) nv[i] = m_valid[i-1];
                if (hold_front) begin
                    nv[EX] = 0;
                end else begin
                    nv[EX] = m_valid[EX-1];
                    for (int i = EX - 1; i >= 1; i--) nv[i] = m_valid[i-1];
                    nv[0] = 1;
                    if (redir) for (int i = 1; i <= EX; i++) nv[i] = 0;
                end
                m_igot = 0;
                m_dgot = 0;
            end else begin
                m_igot = m_igot || inst_mem_resp;
                m_dgot = m_dgot || (dreq && data_mem_resp);
            end
            for (int i = 0; i < NS; i++) m_valid[i] = nv[i];
        end
    end

    // Inputs: r, iresp, rd, wr, dresp, jal, jalr, br, br_en, load_use; returns at the checking edge.
    task automatic cyc(input bit r, ir, rd, wr, dr, jl, jr, br, be, lu);
        rst = r; inst_mem_resp = ir; data_rd_req = rd; data_wr_req = wr; data_mem_resp = dr;
        ex_is_jal = jl; ex_is_jalr = jr; ex_is_br = br; br_en = be; load_use = lu;
        @(negedge clk);
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("T1 reset valid", stage_valid, 5'b00001);
        chk("T1 reset iread", inst_mem_read, 1'b0);
        chk("T1 reset adv", advance, 1'b0);
        chk("T1 reset load", stage_load, 5'b00000);
`ifdef PIPE_PERF_CNT_EN
        chk("T1 reset stall_cnt", stall_cnt, 0);
`endif
        go();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("T1 iread after release", inst_mem_read, 1'b1);
        go();
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("fill adv", advance, 1'b1);
            go();
        end
        cyc(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        chk("T2 dread before resp", data_mem_read, 1'b1);
        chk("T2 no adv on d only", advance, 1'b0);
        go();
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("T2 dread dropped", data_mem_read, 1'b0);
        chk("T2 still waiting", advance, 1'b0);
        go();
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("T2 adv on i resp", advance, 1'b1);
        chk("T2 dread held low", data_mem_read, 1'b0);
        chk("T2 load all", stage_load, 5'b11111);
        go();
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("T3 pc_mux br", pc_mux_sel, 2'd1);
        go();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("T3 squash", stage_valid, 5'b11001);
        go();
        for (int k = 0; k < 2; k++) begin
            cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            go();
        end
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("T4 pc_mux jalr", pc_mux_sel, 2'd2);
        go();
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("T5 load_use load", stage_load, 5'b11100);
        go();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("T5 bubble valid", stage_valid, 5'b01011);
        go();
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        go();
        cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, 1);
        chk("T5 redirect wins load", stage_load, 5'b11111);
        chk("T5 pc_mux jal", pc_mux_sel, 2'd1);
        go();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("T5 jal squash", stage_valid, 5'b01001);
        go();
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("T6 wait for d", advance, 1'b0);
        go();
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("T6 i_done iread", inst_mem_read, 1'b0);
        go();
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("T6 reset valid", stage_valid, 5'b00001);
        chk("T6 reset dread", data_mem_read, 1'b0);
        chk("T6 reset adv", advance, 1'b0);
`ifdef PIPE_PERF_CNT_EN
        chk("T6 reset stall_cnt", stall_cnt, 0);
        chk("T6 reset flush_cnt", flush_cnt, 0);
`endif
        go();
        cyc(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        chk("T6 flags cleared iread", inst_mem_read, 1'b1);
        chk("T6 no adv", advance, 1'b0);
        go();

        for (int k = 0; k < 1500; k++) begin
            cyc($urandom_range(0, 49) != 0,
                $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40,
                $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 40,
                $urandom_range(0, 99) < 8,  $urandom_range(0, 99) < 8,
                $urandom_range(0, 99) < 20, $urandom_range(0, 1) == 1,
                $urandom_range(0, 99) < 20);
            go();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
